// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read-side stream adapter.
// Compile-time constants only; no timing or flow-control behaviour.
package fifo_pkg;
  localparam int FIFO_WIDTH    = 16;
  localparam int BUF_DEPTH_DEF = 3;
  localparam int ERR_CNT_W_DEF = 8;

  typedef logic [FIFO_WIDTH-1:0] fifo_data_t;
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Ring buffer with push/pop/clear that holds words already read from the FIFO; head is valid while occ != 0.
// Zero-latency head; the caller must never push when full, because this buffer cannot backpressure.
module fifo_rd_skid_buf import fifo_pkg::*; #(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = BUF_DEPTH_DEF,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  // Compare-and-reset wrap so a non power-of-two depth never aliases.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok = pop && (occ != '0);
  assign full   = (occ == OCC_W'(DEPTH));
  assign head   = (occ != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({push, pop_ok})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a sync FIFO into a valid/ready stream; rd_en in cycle t gives m_valid in t+2 when the buffer is empty.
// Backpressure via buffer occupancy only: reads stop when buffered plus in-flight words reach BUF_DEPTH.
module fifo_rd_stream_adapter import fifo_pkg::*; #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic                  flush,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  underflow_err,
  output logic [ERR_CNT_W-1:0]  underflow_cnt
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  if (BUF_DEPTH < 2) begin : g_depth_chk
    $fatal(1, "BUF_DEPTH must be at least 2");
  end

  logic             inflight_q;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic [OCC_W:0]   pending;
  logic             rd_room;
  logic             push;
  logic             pop;

  // Count the in-flight word so the buffer always has room for it when it lands.
  assign pending    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
  assign rd_room    = !full && (pending < (OCC_W + 1)'(BUF_DEPTH));
  assign fifo_rd_en = !rst && !flush && !fifo_empty && rd_room;

  assign push    = inflight_q && !flush && !fifo_underflow;
  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign busy    = m_valid || inflight_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_err <= 1'b0;
      underflow_cnt <= '0;
    end else if (fifo_underflow) begin
      underflow_err <= 1'b1;
      if (underflow_cnt != '1) begin
        underflow_cnt <= underflow_cnt + ERR_CNT_W'(1);
      end
    end
  end

  fifo_rd_skid_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ),
    .full      (full)
  );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO, word-level scoreboard, per-feature scenarios.
module tb_fifo_rd_stream_adapter;
  import fifo_pkg::*;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       m_ready = 1'b0;
  logic       force_uf = 1'b0;
  logic       empty_ovr = 1'b0;
  logic       wr_req = 1'b0;
  fifo_data_t wr_dat = '0;
  fifo_data_t fifo_data_out = '0;
  logic       fifo_empty_m = 1'b1;
  logic       fifo_uf_m = 1'b0;
  logic       fifo_empty;
  logic       fifo_underflow;

  logic       fifo_rd_en, m_valid, busy, underflow_err;
  fifo_data_t m_data;
  logic [7:0] underflow_cnt;
  logic       rd_en2, m_valid2, busy2, uf_err2;
  fifo_data_t m_data2;
  logic [1:0] uf_cnt2;

  assign fifo_empty     = fifo_empty_m && !empty_ovr;
  assign fifo_underflow = fifo_uf_m || force_uf;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter u_dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .underflow_err(underflow_err), .underflow_cnt(underflow_cnt)
  );

  fifo_rd_stream_adapter #(.ERR_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .fifo_rd_en(rd_en2), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .flush(flush),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready), .busy(busy2),
    .underflow_err(uf_err2), .underflow_cnt(uf_cnt2)
  );

  // Behavioural synchronous FIFO: registered read data, registered empty/underflow.
  fifo_data_t fq[$];
  always @(posedge clk) begin
    fifo_uf_m <= 1'b0;
    if (fifo_rd_en) begin
      if (fq.size() > 0) fifo_data_out <= fq.pop_front();
      else fifo_uf_m <= 1'b1;
    end
    if (wr_req) fq.push_back(wr_dat);
    fifo_empty_m <= (fq.size() == 0);
  end

  // Word-level reference: exp_q holds words read from the FIFO and not yet delivered.
  fifo_data_t exp_q[$];
  fifo_data_t got[$];
  int         got_cyc[$];
  int         rd_log[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic       prev_rd = 1'b0;
  logic       mon_en = 1'b0;
  logic       exp_rd;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_rd = 1'b0;
    end else if (mon_en) begin
      exp_rd = !flush && !fifo_empty && ((exp_q.size() + int'(prev_rd)) < DEPTH);
      total++;
      if (fifo_rd_en !== exp_rd) begin
        bad++;
        if (bad <= 20) $display("FAIL mon_rd_en cyc=%0d got=%b exp=%b", cyc, fifo_rd_en, exp_rd);
      end
      total++;
      if (m_valid !== (exp_q.size() != 0)) begin
        bad++;
        if (bad <= 20) $display("FAIL mon_m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        total++;
        if (m_data !== exp_q[0]) begin
          bad++;
          if (bad <= 20) $display("FAIL mon_m_data cyc=%0d got=%h exp=%h", cyc, m_data, exp_q[0]);
        end
      end
      total++;
      if (busy !== ((exp_q.size() != 0) || prev_rd)) begin
        bad++;
        if (bad <= 20) $display("FAIL mon_busy cyc=%0d got=%b", cyc, busy);
      end
      if (fifo_rd_en) rd_log.push_back(cyc);
      if (m_valid && m_ready && exp_q.size() != 0) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (prev_rd && !fifo_underflow) exp_q.push_back(fifo_data_out);
      prev_rd = fifo_rd_en;
    end
  end

  task automatic preload(input int base, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) fq.push_back(fifo_data_t'(base + i));
  endtask

  task automatic drain();
    bit done = 0;
    flush = 0; wr_req = 0; force_uf = 0; m_ready = 1;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (!busy && fq.size() == 0 && fifo_empty) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout busy=%b fifo_words=%0d", busy, fq.size());
    end
    got.delete(); got_cyc.delete(); rd_log.delete();
  endtask

  task automatic test_reset();
    rst = 1; empty_ovr = 1; m_ready = 1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #2;
      total++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || underflow_cnt !== '0 ||
          busy !== 1'b0 || underflow_err !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs rd_en=%b m_valid=%b m_data=%h cnt=%0d busy=%b err=%b exp all 0",
                 fifo_rd_en, m_valid, m_data, underflow_cnt, busy, underflow_err);
      end
    end
    @(negedge clk);
    rst = 0; empty_ovr = 0; mon_en = 1;
  endtask

  task automatic test_stream();
    m_ready = 1;
    preload(16'h0001, 8);
    repeat (16) @(negedge clk);
    total++;
    if (rd_log.size() != 8) begin bad++; $display("FAIL stream_reads got=%0d exp=8", rd_log.size()); end
    if (rd_log.size() == 8) begin
      total++;
      if (rd_log[7] - rd_log[0] != 7) begin
        bad++; $display("FAIL stream_rd_consecutive span=%0d exp=7", rd_log[7] - rd_log[0]);
      end
    end
    total++;
    if (got.size() != 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++;
      if (got[i] !== fifo_data_t'(i + 1)) begin
        bad++; $display("FAIL stream_word idx=%0d got=%h exp=%h", i, got[i], i + 1);
      end
    end
    if (got.size() == 8 && rd_log.size() > 0) begin
      total++;
      if (got_cyc[0] - rd_log[0] != 2) begin
        bad++; $display("FAIL stream_latency got=%0d exp=2", got_cyc[0] - rd_log[0]);
      end
      total++;
      if (got_cyc[7] - got_cyc[0] != 7) begin
        bad++; $display("FAIL stream_gapless span=%0d exp=7", got_cyc[7] - got_cyc[0]);
      end
    end
    total++;
    if (underflow_cnt !== 8'd0) begin bad++; $display("FAIL stream_underflow got=%0d exp=0", underflow_cnt); end
    drain();
  endtask

  task automatic test_backpressure();
    m_ready = 0;
    preload(16'h00A0, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (i >= 6) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== 16'h00A0) begin
          bad++; $display("FAIL bp_hold cyc=%0d m_valid=%b m_data=%h exp 1/00a0", i, m_valid, m_data);
        end
      end
    end
    total++;
    if (rd_log.size() != 3) begin bad++; $display("FAIL bp_reads got=%0d exp=3", rd_log.size()); end
    @(negedge clk);
    m_ready = 1;
    repeat (12) @(negedge clk);
    total++;
    if (got.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      total++;
      if (got[i] !== fifo_data_t'(16'h00A0 + i)) begin
        bad++; $display("FAIL bp_word idx=%0d got=%h exp=%h", i, got[i], 16'h00A0 + i);
      end
    end
    if (got.size() == 5) begin
      total++;
      if (got_cyc[4] - got_cyc[0] != 4) begin
        bad++; $display("FAIL bp_gapless span=%0d exp=4", got_cyc[4] - got_cyc[0]);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    bit         done = 0;
    bit         nxt_valid = 0;
    fifo_data_t nxt = '0;
    int         rem = 0;
    int         got_idx = -1;
    m_ready = 0;
    preload(16'h0100, 8);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      m_ready = (i < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      if (done && got_idx < 0) got_idx = got.size();
      if (!done && exp_q.size() == 2 && prev_rd) begin
        flush = 1;
        done = 1;
        rem = fq.size();
        nxt_valid = (fq.size() > 0);
        if (nxt_valid) nxt = fq[0];
      end else begin
        flush = 0;
      end
    end
    flush = 0;
    total++;
    if (!done) begin bad++; $display("FAIL flush_condition_not_reached got=0 exp=1"); end
    if (done && got_idx >= 0) begin
      total++;
      if (got.size() - got_idx != rem) begin
        bad++; $display("FAIL flush_remaining got=%0d exp=%0d", got.size() - got_idx, rem);
      end
      if (nxt_valid && got.size() > got_idx) begin
        total++;
        if (got[got_idx] !== nxt) begin
          bad++; $display("FAIL flush_next_word got=%h exp=%h", got[got_idx], nxt);
        end
      end
    end
    drain();
  endtask

  task automatic test_empty_boundary();
    int nw = 0;
    int viol = 0;
    m_ready = 1;
    preload(16'h0200, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_req = (i % 4 == 0) && (nw < 6);
      if (wr_req) begin wr_dat = fifo_data_t'(16'h0201 + nw); nw++; end
      #2;
      if (fifo_rd_en && fifo_empty) viol++;
    end
    wr_req = 0;
    total++;
    if (viol != 0) begin bad++; $display("FAIL empty_read_issued got=%0d exp=0", viol); end
    total++;
    if (got.size() != 7) begin bad++; $display("FAIL empty_count got=%0d exp=7", got.size()); end
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      total++;
      if (got[i] !== fifo_data_t'(16'h0200 + i)) begin
        bad++; $display("FAIL empty_word idx=%0d got=%h exp=%h", i, got[i], 16'h0200 + i);
      end
    end
    total++;
    if (underflow_cnt !== 8'd0) begin bad++; $display("FAIL empty_underflow got=%0d exp=0", underflow_cnt); end
    drain();
  endtask

  task automatic test_random();
    int wseq = 16'h1000;
    int ooo = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr_req  = 1'($urandom_range(0, 1));
      wr_dat  = fifo_data_t'(wseq);
      if (wr_req) wseq++;
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    wr_req = 0; flush = 0; m_ready = 1;
    repeat (60) @(negedge clk);
    for (int i = 1; i < got.size(); i++) if (got[i] <= got[i-1]) ooo++;
    total++;
    if (ooo != 0) begin bad++; $display("FAIL random_order out_of_order=%0d exp=0", ooo); end
    total++;
    if (got.size() == 0) begin bad++; $display("FAIL random_no_traffic got=0 exp>0"); end
    drain();
  endtask

  task automatic test_underflow();
    bit hit = 0;
    total++;
    if (underflow_err !== 1'b0 || underflow_cnt !== 8'd0 || uf_cnt2 !== 2'd0) begin
      bad++; $display("FAIL uf_initial err=%b cnt=%0d cnt2=%0d exp 0", underflow_err, underflow_cnt, uf_cnt2);
    end
    m_ready = 1;
    preload(16'h0300, 1);
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (prev_rd) hit = 1;
    end
    force_uf = 1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    force_uf = 0;
    #2;
    total++;
    if (!hit) begin bad++; $display("FAIL uf_inflight_not_seen got=0 exp=1"); end
    total++;
    if (underflow_err !== 1'b1 || underflow_cnt !== 8'd3) begin
      bad++; $display("FAIL uf_count3 err=%b cnt=%0d exp err=1 cnt=3", underflow_err, underflow_cnt);
    end
    total++;
    if (uf_cnt2 !== 2'd3 || uf_err2 !== 1'b1) begin
      bad++; $display("FAIL uf_narrow3 cnt=%0d err=%b exp 3/1", uf_cnt2, uf_err2);
    end
    @(negedge clk); force_uf = 1;
    @(negedge clk);
    @(negedge clk); force_uf = 0;
    #2;
    total++;
    if (underflow_cnt !== 8'd5) begin bad++; $display("FAIL uf_count5 got=%0d exp=5", underflow_cnt); end
    total++;
    if (uf_cnt2 !== 2'd3) begin bad++; $display("FAIL uf_saturate got=%0d exp=3", uf_cnt2); end
    repeat (6) @(negedge clk);
    total++;
    if (got.size() != 0) begin bad++; $display("FAIL uf_push_suppressed got=%0d exp=0", got.size()); end
    total++;
    if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", underflow_err); end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_empty_boundary();
    test_random();
    test_underflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout time=%0t limit=400000", $time);
    $fatal(1, "timeout");
  end

endmodule
